// File: rtl/serial_frame_pkg.sv
// Shared types and default parameters for the serial frame receiver.
package serial_frame_pkg;

   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         MAX_LEN_DEF   = 16;
   localparam int         LEN_W_DEF     = 5;

endpackage

// File: rtl/bit_shifter8.sv
// 8-bit serial-to-parallel shifter: sliding window, bit counter, byte-complete strobe.
module bit_shifter8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_vld,
   input  logic       clr,
   input  logic       cnt_en,
   output logic [7:0] window_nxt,
   output logic       byte_done
);

   logic [7:0] window_q, window_d;
   logic [2:0] bitcnt_q, bitcnt_d;

   // Kept as separate assigns so the clear path (which depends on byte_done) forms no comb loop.
   assign window_nxt = {window_q[6:0], bit_in};
   assign byte_done  = bit_vld && cnt_en && (bitcnt_q == 3'd7);

   always_comb begin
      window_d = window_q;
      bitcnt_d = bitcnt_q;
      if (clr) begin
         window_d = 8'h00;
         bitcnt_d = 3'd0;
      end else begin
         if (bit_vld) window_d = window_nxt;
         if (!cnt_en)      bitcnt_d = 3'd0;
         else if (bit_vld) bitcnt_d = bitcnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window_q <= 8'h00;
         bitcnt_q <= 3'd0;
      end else begin
         window_q <= window_d;
         bitcnt_q <= bitcnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_rx_ctrl.sv
// Frame controller: SYNC hunt, length, payload delivery over valid/ready, XOR checksum check.
module serial_frame_rx_ctrl
   import serial_frame_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_LEN   = MAX_LEN_DEF,
   parameter int         LEN_W     = LEN_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_vld,
   input  logic       flush,
   output logic [7:0] byte_out,
   output logic       byte_vld,
   input  logic       byte_rdy,
   output logic       byte_sof,
   output logic       byte_eof,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [7:0]       chk_q, chk_d, byte_q, byte_d;
   logic             first_q, first_d, vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
   logic             ok_q, ok_d, err_q, err_d;

   logic [7:0] win_nxt;
   logic       byte_done, sh_clr, cnt_en;

   assign cnt_en = (state_q != HUNT);
   // A finished frame also wipes the window so checksum bits cannot seed a false SYNC.
   assign sh_clr = flush || ((state_q == CHECK) && byte_done);

   bit_shifter8 u_shift (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_vld    (bit_vld),
      .clr        (sh_clr),
      .cnt_en     (cnt_en),
      .window_nxt (win_nxt),
      .byte_done  (byte_done)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      chk_d   = chk_q;
      first_d = first_q;
      byte_d  = byte_q;
      vld_d   = vld_q;
      sof_d   = sof_q;
      eof_d   = eof_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;

      if (vld_q && byte_rdy) vld_d = 1'b0;

      if (flush) begin
         state_d = HUNT;
         vld_d   = 1'b0;
         chk_d   = 8'h00;
         rem_d   = '0;
      end else begin
         case (state_q)
            HUNT: if (bit_vld && (win_nxt == SYNC_BYTE)) state_d = LEN;
            LEN: if (byte_done) begin
               if ((win_nxt == 8'h00) || (win_nxt > MAX_LEN_B)) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  rem_d   = win_nxt[LEN_W-1:0];
                  chk_d   = 8'h00;
                  first_d = 1'b1;
                  state_d = PAYLOAD;
               end
            end
            PAYLOAD: if (byte_done) begin
               if (vld_q && !byte_rdy) begin
                  // Consumer still owns the previous byte: keep it, drop the new one.
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  byte_d  = win_nxt;
                  vld_d   = 1'b1;
                  sof_d   = first_q;
                  eof_d   = (rem_q == LEN_W'(1));
                  chk_d   = chk_q ^ win_nxt;
                  first_d = 1'b0;
                  rem_d   = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) state_d = CHECK;
               end
            end
            CHECK: if (byte_done) begin
               ok_d    = (win_nxt == chk_q);
               err_d   = (win_nxt != chk_q);
               chk_d   = 8'h00;
               state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         rem_q   <= '0;
         chk_q   <= 8'h00;
         first_q <= 1'b0;
         byte_q  <= 8'h00;
         vld_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         chk_q   <= chk_d;
         first_q <= first_d;
         byte_q  <= byte_d;
         vld_q   <= vld_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   assign byte_out  = byte_q;
   assign byte_vld  = vld_q;
   assign byte_sof  = sof_q;
   assign byte_eof  = eof_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;
   assign busy      = (state_q != HUNT);

endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
// Directed and randomized frames against a bit-stream reference model with a delivery scoreboard.
module tb_serial_frame_rx_ctrl;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       bit_in = 1'b0, bit_vld = 1'b0, flush = 1'b0, byte_rdy = 1'b0;
   logic [7:0] byte_out;
   logic       byte_vld, byte_sof, byte_eof, frame_ok, frame_err, busy;

   serial_frame_rx_ctrl dut (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
      .byte_out(byte_out), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
      .byte_sof(byte_sof), .byte_eof(byte_eof), .frame_ok(frame_ok),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;
   logic [9:0] got_q[$], exp_q[$];
   int got_ok = 0, got_err = 0, exp_ok = 0, exp_err = 0, both_cnt = 0;
   bit rdy_rand = 0;
   int hold = 0;

   // reference model state: bit-level view of the frame grammar
   logic [7:0] m_win = 8'h00, m_chk = 8'h00;
   int m_st = 0, m_nb = 0, m_rem = 0;
   bit m_first = 0, m_on = 1;

   always @(negedge clk) if (rst_n) begin
      if (byte_vld && byte_rdy) got_q.push_back({byte_sof, byte_eof, byte_out});
      if (frame_ok)  got_ok++;
      if (frame_err) got_err++;
      if (frame_ok && frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) begin
         if (byte_vld) hold++; else hold = 0;
         byte_rdy = (hold >= 3) || ($urandom_range(0, 1) == 1);
      end
   endtask

   task automatic model_bit(input logic b);
      if (!m_on) return;
      m_win = {m_win[6:0], b};
      if (m_st == 0) begin
         if (m_win == 8'hA5) begin m_st = 1; m_nb = 0; end
      end else begin
         m_nb++;
         if (m_nb == 8) begin
            m_nb = 0;
            if (m_st == 1) begin
               if (m_win == 0 || m_win > 16) begin exp_err++; m_st = 0; end
               else begin m_rem = int'(m_win); m_chk = 0; m_first = 1; m_st = 2; end
            end else if (m_st == 2) begin
               exp_q.push_back({m_first, (m_rem == 1), m_win});
               m_chk ^= m_win; m_first = 0; m_rem--;
               if (m_rem == 0) m_st = 3;
            end else begin
               if (m_win == m_chk) exp_ok++; else exp_err++;
               m_st = 0; m_win = 0;
            end
         end
      end
   endtask

   task automatic model_clear();
      m_win = 0; m_chk = 0; m_st = 0; m_nb = 0; m_rem = 0;
   endtask

   task automatic clear_scb();
      got_q.delete(); exp_q.delete();
      got_ok = 0; got_err = 0; exp_ok = 0; exp_err = 0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      bit_in = b; bit_vld = 1'b1;
      model_bit(b);
      tick();
      bit_vld = 1'b0;
      repeat (gap) tick();
   endtask

   // gap < 0 selects a random 0..2 cycle gap after each bit
   task automatic send_byte(input logic [7:0] v, input int gap);
      for (int i = 7; i >= 0; i--)
         send_bit(v[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
   endtask

   task automatic compare(input string tag);
      rdy_rand = 0; byte_rdy = 1'b1;
      repeat (4) tick();
      check({tag, "_cnt"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_byte"}, got_q[i], exp_q[i]);
      check({tag, "_ok"}, got_ok, exp_ok);
      check({tag, "_err"}, got_err, exp_err);
   endtask

   initial begin
      logic [7:0] len, c, p;
      int nj;

      // reset
      repeat (3) tick();
      check("rst_outs", {byte_out, byte_vld, byte_sof, byte_eof, frame_ok, frame_err, busy}, 0);
      rst_n = 1'b1; byte_rdy = 1'b1;
      tick();

      // 1 good frame with timing checks
      clear_scb(); model_clear();
      send_byte(8'hA5, 0); send_byte(8'h02, 0);
      check("t1_busy", busy, 1);
      send_byte(8'h3C, 0);
      check("t1_b0", {byte_vld, byte_sof, byte_eof, byte_out}, {3'b110, 8'h3C});
      send_byte(8'hC3, 0);
      check("t1_b1", {byte_vld, byte_sof, byte_eof, byte_out}, {3'b101, 8'hC3});
      send_byte(8'hFF, 0);
      check("t1_pulse", {frame_ok, frame_err, busy}, 3'b100);
      tick();
      check("t1_pulse_1cyc", frame_ok, 0);
      compare("t1");
      check("t1_first", got_q.size() > 0 ? got_q[0] : 10'h0, 10'h23C);

      // 2 bad checksum
      clear_scb();
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h3C, 0);
      send_byte(8'hC3, 0); send_byte(8'h00, 0);
      check("t2_pulse", {frame_ok, frame_err}, 2'b01);
      compare("t2");
      check("t2_okcnt", got_ok, 0);

      // 3 illegal lengths
      clear_scb();
      send_byte(8'hA5, 0); send_byte(8'h00, 0);
      check("t3_len0", {frame_err, busy}, 2'b10);
      send_byte(8'hA5, 0); send_byte(8'h11, 0);
      check("t3_len17", {frame_err, busy}, 2'b10);
      compare("t3");
      check("t3_nobytes", got_q.size(), 0);

      // 4 misalignment junk and bit gaps
      clear_scb();
      send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b1, 2);
      send_byte(8'hA5, 2); send_byte(8'h02, 2); send_byte(8'h3C, 2);
      send_byte(8'hC3, 2); send_byte(8'hFF, 2);
      compare("t4");
      check("t4_eof", got_q.size() > 1 ? got_q[1] : 10'h0, 10'h1C3);
      check("t4_okcnt", got_ok, 1);

      // 5 backpressure overflow
      flush = 1'b1; tick(); flush = 1'b0;
      clear_scb(); model_clear(); m_on = 0; byte_rdy = 1'b0;
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h3C, 0);
      check("t5_hold", {byte_vld, byte_out}, {1'b1, 8'h3C});
      send_byte(8'hC3, 0);
      check("t5_ovf", {frame_err, frame_ok, busy, byte_vld, byte_sof, byte_eof, byte_out},
            {6'b100110, 8'h3C});
      send_byte(8'hFF, 0);
      check("t5_still", {byte_vld, byte_out, frame_ok}, {1'b1, 8'h3C, 1'b0});
      byte_rdy = 1'b1; tick();
      check("t5_drop", byte_vld, 0);
      check("t5_cnt", got_q.size(), 1);
      check("t5_errcnt", got_err, 1);
      m_on = 1;

      // 6a flush while a payload byte is pending
      flush = 1'b1; tick(); flush = 1'b0;
      clear_scb(); model_clear(); byte_rdy = 1'b0;
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h3C, 0);
      check("t6_pend", byte_vld, 1);
      flush = 1'b1; tick(); flush = 1'b0;
      check("t6_flush", {byte_vld, busy, frame_ok, frame_err}, 0);
      clear_scb(); model_clear(); byte_rdy = 1'b1;
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h3C, 0);
      send_byte(8'hC3, 0); send_byte(8'hFF, 0);
      compare("t6a");

      // 6b reset mid-LEN
      clear_scb();
      send_byte(8'hA5, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
      check("t6_busy", busy, 1);
      rst_n = 1'b0; #1;
      check("t6_rst", {byte_vld, busy, frame_ok, frame_err}, 0);
      tick(); rst_n = 1'b1; tick();
      clear_scb(); model_clear();
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h3C, 0);
      send_byte(8'hC3, 0); send_byte(8'hFF, 0);
      compare("t6b");

      // 7 SYNC value as payload
      clear_scb();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'hA5, 0); send_byte(8'hA5, 0);
      compare("t7");

      // 8 randomized frames, junk, gaps and ready
      clear_scb(); rdy_rand = 1; hold = 0;
      for (int f = 0; f < 10; f++) begin
         nj = int'($urandom_range(0, 5));
         for (int j = 0; j < nj; j++) send_bit(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
         case ($urandom_range(0, 7))
            0:       len = 8'h00;
            1:       len = 8'h11;
            default: len = 8'($urandom_range(1, 16));
         endcase
         send_byte(8'hA5, -1); send_byte(len, -1);
         if (len >= 1 && len <= 16) begin
            c = 8'h00;
            for (int k = 0; k < int'(len); k++) begin
               p = 8'($urandom);
               c ^= p;
               send_byte(p, -1);
            end
            if ($urandom_range(0, 3) == 0) c = ~c;
            send_byte(c, -1);
         end
      end
      compare("t8");

      check("ok_err_excl", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
